// File: rtl/datagram_tx.sv
// Serialiser for the game-core to display datagram link, with a one-deep pending buffer.
// Define DGRAM_CRC8_EN to append a CRC-8 (poly 0x07) byte after the payload.
module datagram_tx #(
  parameter int unsigned MSG_WIDTH    = 512,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter logic [7:0]  SYNC_WORD    = 8'hA5,
  parameter int unsigned GAP_BITS     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MSG_WIDTH-1:0] datagram,
  input  logic                 send,
  output logic                 ready,
  output logic                 busy,
  output logic                 tx_line,
  output logic                 tx_frame,
  output logic                 frame_done,
  output logic                 overrun
);

  localparam int unsigned CntW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IdxMax = (MSG_WIDTH > 8) ?
                                   ((MSG_WIDTH > GAP_BITS) ? MSG_WIDTH : GAP_BITS) :
                                   ((GAP_BITS > 8) ? GAP_BITS : 8);
  localparam int unsigned IdxW   = $clog2(IdxMax);

  localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] ByteLast = IdxW'(7);
  localparam logic [IdxW-1:0] PayLast  = IdxW'(MSG_WIDTH - 1);
  localparam logic [IdxW-1:0] GapLast  = IdxW'(GAP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StSync,
    StPayload,
`ifdef DGRAM_CRC8_EN
    StCrc,
`endif
    StStop,
    StGap
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       clk_cnt_q, clk_cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [MSG_WIDTH-1:0]  shift_q, shift_d;
  logic [MSG_WIDTH-1:0]  pend_q, pend_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  bit_end;
  logic                  pend_taken;
`ifdef DGRAM_CRC8_EN
  logic [7:0]            crc_q, crc_d;
`endif

  assign bit_end = (clk_cnt_q == CntLast);

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = (state_q == StIdle || bit_end) ? '0 : clk_cnt_q + 1'b1;
    idx_d        = idx_q;
    shift_d      = shift_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    overrun_d    = 1'b0;
    pend_taken   = 1'b0;
    tx_line      = 1'b1;
    tx_frame     = 1'b0;
    frame_done   = 1'b0;
`ifdef DGRAM_CRC8_EN
    crc_d        = crc_q;
`endif

    unique case (state_q)
      StIdle: begin
        idx_d = '0;
        // A pending snapshot can only be here if it was posted in the final gap cycle.
        if (pend_valid_q) begin
          shift_d      = pend_q;
          pend_valid_d = 1'b0;
          pend_taken   = 1'b1;
          state_d      = StStart;
        end
      end
      StStart: begin
        tx_line  = 1'b0;
        tx_frame = 1'b1;
`ifdef DGRAM_CRC8_EN
        crc_d    = '0;
`endif
        if (bit_end) begin
          idx_d   = '0;
          state_d = StSync;
        end
      end
      StSync: begin
        tx_line  = SYNC_WORD[idx_q[2:0]];
        tx_frame = 1'b1;
        if (bit_end) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == ByteLast) begin
            idx_d   = '0;
            state_d = StPayload;
          end
        end
      end
      StPayload: begin
        tx_line  = shift_q[0];
        tx_frame = 1'b1;
        if (bit_end) begin
          shift_d = shift_q >> 1;
`ifdef DGRAM_CRC8_EN
          crc_d   = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ shift_q[0]) ? 8'h07 : 8'h00);
`endif
          idx_d   = idx_q + 1'b1;
          if (idx_q == PayLast) begin
            idx_d   = '0;
`ifdef DGRAM_CRC8_EN
            state_d = StCrc;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef DGRAM_CRC8_EN
      StCrc: begin
        tx_line  = crc_q[idx_q[2:0]];
        tx_frame = 1'b1;
        if (bit_end) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == ByteLast) begin
            idx_d   = '0;
            state_d = StStop;
          end
        end
      end
`endif
      StStop: begin
        tx_frame = 1'b1;
        if (bit_end) begin
          frame_done = 1'b1;
          idx_d      = '0;
          state_d    = StGap;
        end
      end
      StGap: begin
        if (bit_end) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == GapLast) begin
            idx_d = '0;
            if (pend_valid_q) begin
              shift_d      = pend_q;
              pend_valid_d = 1'b0;
              pend_taken   = 1'b1;
              state_d      = StStart;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (send) begin
      if (state_q == StIdle && !pend_valid_q) begin
        shift_d = datagram;
        state_d = StStart;
      end else begin
        // Latest wins; only a snapshot that was never handed to the shifter counts as lost.
        if (pend_valid_q && !pend_taken) overrun_d = 1'b1;
        pend_d       = datagram;
        pend_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      clk_cnt_q    <= '0;
      idx_q        <= '0;
      pend_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      idx_q        <= idx_d;
      pend_valid_q <= pend_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    pend_q  <= pend_d;
`ifdef DGRAM_CRC8_EN
    crc_q   <= crc_d;
`endif
  end

  assign ready   = ~pend_valid_q;
  assign busy    = (state_q != StIdle);
  assign overrun = overrun_q;

endmodule
